// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operation codes and datapath mux select values.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_sel = IMM_S;
            OP_BRANCH: imm_sel = IMM_B;
            OP_JAL:    imm_sel = IMM_J;
            default:   imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp plus instruction fields to the ALU operation code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    // ALU operation select
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // only R-type (op[5]=1) may select sub; addi never does
                    3'b000: begin
                        if (op5 && funct7b5) begin
                            ALUControl = ALU_SUB;
                        end else begin
                            ALUControl = ALU_ADD;
                        end
                    end
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style main FSM for a multicycle RISC-V core; all outputs are decoded
// from the state register and the current instruction fields.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter bit BNE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite
);

    state_t     state_q, state_d;
    logic [1:0] alu_op_s;
    logic       branch_s;
    logic       pc_update_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       taken_s;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state control decode
    always_comb begin
        AdrSrc      = 1'b0;
        mem_write_s = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        alu_op_s    = ALUOP_ADD;
        reg_write_s = 1'b0;
        branch_s    = 1'b0;
        pc_update_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                pc_update_s = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = SRCA_RS1;
                alu_op_s = ALUOP_FUNC;
            end
            S_EXECUTEI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                alu_op_s = ALUOP_FUNC;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = SRCA_RS1;
                alu_op_s = ALUOP_SUB;
                branch_s = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                pc_update_s = 1'b1;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

    // Branch resolution, immediate select and reset gating of the write strobes
    always_comb begin
        if (BNE_EN && (funct3 == 3'b001)) begin
            taken_s = ~Zero;
        end else begin
            taken_s = Zero;
        end
        PCWrite  = pc_update_s | (branch_s & taken_s);
        ImmSrc   = imm_sel(op);
        // the state only returns to FETCH at the next edge, so block writes now
        MemWrite = mem_write_s & ~reset;
        RegWrite = reg_write_s & ~reset;
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op_s),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed and random instructions compared cycle by cycle
// against an instruction-level model of the controller's control words.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    logic       PCWrite0, AdrSrc0, MemWrite0, IRWrite0, RegWrite0;
    logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ImmSrc0;
    logic [2:0] ALUControl0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.BNE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite)
    );

    multicycle_controller #(.BNE_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite0), .AdrSrc(AdrSrc0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
        .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
        .ALUControl(ALUControl0), .ImmSrc(ImmSrc0), .RegWrite(RegWrite0)
    );

    // Instruction classes and the work done in each cycle of an instruction
    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_BAD = 6;
    localparam int W_FETCH = 0, W_DECODE = 1, W_ADDR = 2, W_RD = 3, W_RDWB = 4, W_WR = 5,
                   W_XR = 6, W_XI = 7, W_WB = 8, W_BR = 9, W_JAL = 10;

    int cpi [7] = '{5, 4, 4, 4, 3, 4, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input logic [6:0] o);
        case (o)
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            default:    return C_BAD;
        endcase
    endfunction

    function automatic int work_of(input int c, input int k);
        if (k == 0) return W_FETCH;
        if (k == 1) return W_DECODE;
        case (c)
            C_LW:    return (k == 2) ? W_ADDR : ((k == 3) ? W_RD : W_RDWB);
            C_SW:    return (k == 2) ? W_ADDR : W_WR;
            C_R:     return (k == 2) ? W_XR : W_WB;
            C_I:     return (k == 2) ? W_XI : W_WB;
            C_BR:    return W_BR;
            C_JAL:   return (k == 2) ? W_JAL : W_WB;
            default: return W_FETCH;
        endcase
    endfunction

    function automatic logic [2:0] arith(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'b000:  return (op5 && f7) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic taken(input logic bne_en);
        if (bne_en && funct3 == 3'b001) return !Zero;
        return Zero;
    endfunction

    task automatic check_cycle(input int c, input int k);
        logic pcw, pcw0, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        int w;
        pcw = 1'b0; pcw0 = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
        rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
        case (c)
            C_SW:    imm = 2'd1;
            C_BR:    imm = 2'd2;
            C_JAL:   imm = 2'd3;
            default: imm = 2'd0;
        endcase
        w = work_of(c, k);
        case (w)
            W_FETCH:  begin irw = 1'b1; sb = 2'd2; rs = 2'd2; pcw = 1'b1; pcw0 = 1'b1; end
            W_DECODE: begin sa = 2'd1; sb = 2'd1; end
            W_ADDR:   begin sa = 2'd2; sb = 2'd1; end
            W_RD:     adr = 1'b1;
            W_RDWB:   begin rs = 2'd1; rw = 1'b1; end
            W_WR:     begin adr = 1'b1; mw = 1'b1; end
            W_XR:     begin sa = 2'd2; alu = arith(funct3, op[5], funct7b5); end
            W_XI:     begin sa = 2'd2; sb = 2'd1; alu = arith(funct3, op[5], funct7b5); end
            W_WB:     rw = 1'b1;
            W_BR:     begin sa = 2'd2; alu = 3'd1; pcw = taken(1'b1); pcw0 = taken(1'b0); end
            W_JAL:    begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; pcw0 = 1'b1; end
            default:  irw = 1'b0;
        endcase
        chk($sformatf("ctrl op=%b f3=%0d z=%0b cyc=%0d", op, funct3, Zero, k + 1),
            {16'd0, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite},
            {16'd0, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw});
        chk($sformatf("pcwrite_nobne op=%b f3=%0d z=%0b cyc=%0d", op, funct3, Zero, k + 1),
            {31'd0, PCWrite0}, {31'd0, pcw0});
    endtask

    // Entered one time unit after the edge that starts FETCH; leaves at the same
    // point of the next instruction's FETCH cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                             input logic z);
        int c;
        op = o; funct3 = f; funct7b5 = f7; Zero = z;
        c = cls_of(o);
        for (int k = 0; k < cpi[c]; k++) begin
            #1;
            check_cycle(c, k);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] ro;
        int sel;
        reset = 1'b1; op = 7'b0100011; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("reset_regwrite", {31'd0, RegWrite}, 32'd0);
        reset = 1'b0;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b1);
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
        run_instr(7'b0010011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0);
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0);

        // store interrupted by a three-cycle reset in its write cycle
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_cycle(C_SW, k);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("rst_memwrite_first", {31'd0, MemWrite}, 32'd0);
        chk("rst_regwrite_first", {31'd0, RegWrite}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_memwrite_hold%0d", k), {31'd0, MemWrite}, 32'd0);
            chk($sformatf("rst_regwrite_hold%0d", k), {31'd0, RegWrite}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_irwrite", {31'd0, IRWrite}, 32'd1);
        chk("post_rst_pcwrite", {31'd0, PCWrite}, 32'd1);
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 6));
            case (sel)
                0: ro = 7'b0000011;
                1: ro = 7'b0100011;
                2: ro = 7'b0110011;
                3: ro = 7'b0010011;
                4: ro = 7'b1100011;
                5: ro = 7'b1101111;
                default: begin
                    ro = 7'($urandom_range(0, 127));
                    if (cls_of(ro) != C_BAD) ro = 7'b1111111;
                end
            endcase
            run_instr(ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter BNE_EN, default 1: when 1, funct3=001 on a branch opcode is bne (branch on Zero=0); when 0, every branch is beq.
REQ-002 Clocking: one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-005 op  input  7  instruction opcode, from the instruction register.
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7b5  input  1  instruction bit 30.
REQ-008 Zero  input  1  ALU zero flag.
REQ-009 PCWrite  output  1  enables the PC register.
REQ-010 AdrSrc  output  1  memory address select: 0 = PC, 1 = result.
REQ-011 MemWrite  output  1  data memory write strobe.
REQ-012 IRWrite  output  1  enables the instruction register.
REQ-013 ResultSrc  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-015 ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
REQ-016 ALUControl  output  3  ALU operation code.
REQ-017 ImmSrc  output  2  immediate format select.
REQ-018 RegWrite  output  1  register file write enable.

Function
REQ-019 The block SHALL implement a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
REQ-020 Transitions: FETCH->DECODE; ALUWB, MEMWB, MEMWRITE and BRANCH each go to FETCH.
REQ-021 DECODE on op SHALL go to: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL; any other op -> FETCH.
REQ-022 MEMADR SHALL go to MEMREAD when op=0000011, otherwise to MEMWRITE; MEMREAD->MEMWB; EXECUTER, EXECUTEI and JAL each go to ALUWB.
REQ-023 Per-state outputs (unlisted outputs are 0):
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PC update.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BRANCH: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PC update.
REQ-024 PCWrite SHALL equal PCUpdate OR (Branch AND taken); taken = Zero, or NOT Zero when BNE_EN=1 and funct3=001.
REQ-025 ALUControl from ALUOp:
- ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
- ALUOp 10 by funct3: 000 -> 001 when op[5]=1 and funct7b5=1, else 000; 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); other -> 000.
REQ-026 ImmSrc SHALL be combinational from op in every state: I-type and load -> 00; store -> 01; branch -> 10; jal -> 11; other -> 00.
REQ-027 Cycles per instruction, FETCH to FETCH: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4, illegal op 2.
REQ-028 Outputs SHALL be glitch-free decodes of the state register plus op/funct3/Zero only; the block has no other internal storage.

Reset
REQ-029 reset=1 at a rising clk edge SHALL force state FETCH regardless of current state, including mid-instruction.
REQ-030 While reset is asserted, MemWrite and RegWrite SHALL be 0.
REQ-031 The first cycle after reset deasserts SHALL present FETCH outputs (IRWrite=1, PCWrite=1).

Structure
REQ-032 Shared package riscv_pkg SHALL hold the state enum, opcode constants, ALUControl codes and select encodings.
REQ-033 One sub-module, alu_decoder (ALUOp, funct3, op[5], funct7b5 -> ALUControl), SHALL be instantiated.

Verification
REQ-034 Reset held 3 cycles during MEMWRITE -> state FETCH, MemWrite=0 throughout.
REQ-035 op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5, ResultSrc=01.
REQ-036 op=0100011 -> MemWrite=1 for exactly one cycle (cycle 4) with AdrSrc=1; RegWrite=0 throughout.
REQ-037 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; op=0010011, same funct3/funct7b5 -> ALUControl=000.
REQ-038 Branch op, funct3=000: Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> PCWrite=0. funct3=001 with Zero=0 -> PCWrite=1 when BNE_EN=1, 0 when BNE_EN=0.
REQ-039 op=1111111 -> FETCH, DECODE, FETCH; no MemWrite or RegWrite asserted.
